// File: rtl/cdec8_ctrl.sv
// CDEC8 microsequencer: fetch/execute FSM producing the 17-bit data-path control word.
// ctrl = {mmrw[1:0], fwr, rwr, xdst[3:0], aluop[4:0], xsrc[3:0]}; state exposed for the debug monitor.
module cdec8_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  I,
    input  logic [2:0]  SZCy,
    output logic [16:0] ctrl,
    output logic [7:0]  state,
    output logic        halted,
    output logic        illegal
);

    localparam logic [4:0] ALU_THX = 5'h00;
    localparam logic [4:0] ALU_INC = 5'h01;
    localparam logic [4:0] ALU_ADD = 5'h02;
    localparam logic [4:0] ALU_SUB = 5'h03;
    localparam logic [4:0] ALU_AND = 5'h04;
    localparam logic [4:0] ALU_OR  = 5'h05;
    localparam logic [3:0] NODST   = 4'hF;

    localparam logic [3:0] SRC_PC  = 4'h0;
    localparam logic [3:0] SRC_A   = 4'h1;
    localparam logic [3:0] SRC_R   = 4'h4;
    localparam logic [3:0] SRC_RDR = 4'h5;
    localparam logic [3:0] SRC_IN  = 4'h8;
    localparam logic [3:0] SRC_FF  = 4'hF;
    localparam logic [3:0] DST_PC  = 4'h0;
    localparam logic [3:0] DST_A   = 4'h1;
    localparam logic [3:0] DST_MAR = 4'h4;
    localparam logic [3:0] DST_WDR = 4'h5;
    localparam logic [3:0] DST_T   = 4'h6;
    localparam logic [3:0] DST_I   = 4'h7;
    localparam logic [3:0] DST_OUT = 4'h8;

    typedef enum logic [7:0] {
        S_F0   = 8'h00,
        S_F1   = 8'h01,
        S_F2   = 8'h02,
        S_E0   = 8'h10,
        S_E1   = 8'h11,
        S_E2   = 8'h12,
        S_E3   = 8'h13,
        S_E4   = 8'h14,
        S_HALT = 8'hFF
    } state_t;

    typedef enum logic [3:0] {
        K_NOP, K_HLT, K_MOV, K_LDI, K_LD, K_ST, K_ALU, K_ALUI, K_INC, K_JMP, K_OUT, K_IN
    } kind_t;

    state_t     cur, nxt;
    kind_t      kind;
    logic       bad;
    logic       take;
    logic [1:0] rd, rs;
    logic [3:0] reg_d, reg_s;
    logic [4:0] alu_op;
    logic [1:0] mmrw;
    logic       fwr, rwr;
    logic [3:0] xdst, xsrc;
    logic [4:0] aluop;

    assign rd    = I[3:2];
    assign rs    = I[1:0];
    assign reg_d = {2'b00, rd} + 4'd1;
    assign reg_s = {2'b00, rs} + 4'd1;

    always_comb begin
        kind = K_NOP;
        bad  = 1'b0;
        unique case (I[7:4])
            4'h0: begin
                if (I == 8'h00)      kind = K_NOP;
                else if (I == 8'h01) kind = K_HLT;
                else                 bad  = 1'b1;
            end
            4'h1: if (rd != 2'd3 && rs != 2'd3) kind = K_MOV; else bad = 1'b1;
            4'h2: if (rd != 2'd3) kind = K_LDI; else bad = 1'b1;
            4'h3: if (rd != 2'd3) kind = K_LD;  else bad = 1'b1;
            4'h4: if (rd != 2'd3) kind = K_ST;  else bad = 1'b1;
            4'h5: kind = (rs == 2'd3) ? K_ALUI : K_ALU;
            4'h6: if (rd != 2'd3) kind = K_INC; else bad = 1'b1;
            4'h7: if (I[2:0] != 3'd7) kind = K_JMP; else bad = 1'b1;
            4'h8: begin
                if (I[3:2] == 2'b00 && rs != 2'd3)      kind = K_OUT;
                else if (I[3:2] == 2'b10 && rs != 2'd3) kind = K_IN;
                else                                    bad  = 1'b1;
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        unique case (rd)
            2'd0:    alu_op = ALU_ADD;
            2'd1:    alu_op = ALU_SUB;
            2'd2:    alu_op = ALU_AND;
            default: alu_op = ALU_OR;
        endcase
    end

    // Jump condition uses the flags present during E1.
    always_comb begin
        unique case (I[2:0])
            3'd0:    take = 1'b1;
            3'd1:    take = SZCy[1];
            3'd2:    take = ~SZCy[1];
            3'd3:    take = SZCy[0];
            3'd4:    take = ~SZCy[0];
            3'd5:    take = SZCy[2];
            3'd6:    take = ~SZCy[2];
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)    cur <= S_F0;
        else if (run) cur <= nxt;
    end

    always_comb begin
        nxt   = cur;
        mmrw  = 2'b00;
        fwr   = 1'b0;
        rwr   = 1'b0;
        xdst  = NODST;
        aluop = ALU_THX;
        xsrc  = SRC_FF;
        unique case (cur)
            S_F0: begin
                xsrc = SRC_PC; xdst = DST_MAR; aluop = ALU_INC; rwr = 1'b1; nxt = S_F1;
            end
            S_F1: begin
                xsrc = SRC_R; xdst = DST_PC; mmrw = 2'b10; nxt = S_F2;
            end
            S_F2: begin
                xsrc = SRC_RDR; xdst = DST_I; nxt = S_E0;
            end
            S_E0: begin
                nxt = S_F0;
                unique case (kind)
                    K_HLT: nxt = S_HALT;
                    K_MOV: begin xsrc = reg_s; xdst = reg_d; end
                    K_OUT: begin xsrc = reg_s; xdst = DST_OUT; end
                    K_IN:  begin xsrc = SRC_IN; xdst = reg_d; end
                    K_LDI, K_LD, K_ST, K_ALUI, K_JMP: begin
                        xsrc = SRC_PC; xdst = DST_MAR; aluop = ALU_INC; rwr = 1'b1; nxt = S_E1;
                    end
                    K_ALU: begin xsrc = reg_s; xdst = DST_T; nxt = S_E1; end
                    K_INC: begin
                        xsrc = reg_d; aluop = ALU_INC; rwr = 1'b1; fwr = 1'b1; nxt = S_E1;
                    end
                    default: ;
                endcase
            end
            S_E1: begin
                nxt = S_F0;
                unique case (kind)
                    K_LDI, K_LD, K_ST, K_ALUI, K_JMP: begin
                        xsrc = SRC_R; xdst = DST_PC; mmrw = 2'b10;
                        if (kind != K_JMP || take) nxt = S_E2;
                    end
                    K_ALU: begin
                        xsrc = SRC_A; aluop = alu_op; rwr = 1'b1; fwr = 1'b1; nxt = S_E2;
                    end
                    K_INC: begin xsrc = SRC_R; xdst = reg_d; end
                    default: ;
                endcase
            end
            S_E2: begin
                nxt = S_F0;
                unique case (kind)
                    K_LDI:      begin xsrc = SRC_RDR; xdst = reg_d; end
                    K_LD, K_ST: begin xsrc = SRC_RDR; xdst = DST_MAR; nxt = S_E3; end
                    K_ALUI:     begin xsrc = SRC_RDR; xdst = DST_T; nxt = S_E3; end
                    K_ALU:      begin xsrc = SRC_R; xdst = DST_A; end
                    K_JMP:      begin xsrc = SRC_RDR; xdst = DST_PC; end
                    default: ;
                endcase
            end
            S_E3: begin
                nxt = S_F0;
                unique case (kind)
                    K_LD:   begin mmrw = 2'b10; nxt = S_E4; end
                    K_ST:   begin xsrc = reg_d; xdst = DST_WDR; nxt = S_E4; end
                    K_ALUI: begin
                        xsrc = SRC_A; aluop = alu_op; rwr = 1'b1; fwr = 1'b1; nxt = S_E4;
                    end
                    default: ;
                endcase
            end
            S_E4: begin
                nxt = S_F0;
                unique case (kind)
                    K_LD:   begin xsrc = SRC_RDR; xdst = reg_d; end
                    K_ST:   mmrw = 2'b01;
                    K_ALUI: begin xsrc = SRC_R; xdst = DST_A; end
                    default: ;
                endcase
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_F0;
        endcase
    end

    assign ctrl    = (reset || !run) ? {2'b00, 1'b0, 1'b0, NODST, ALU_THX, SRC_FF}
                                     : {mmrw, fwr, rwr, xdst, aluop, xsrc};
    assign state   = cur;
    assign halted  = (cur == S_HALT);
    assign illegal = (cur == S_E0) && bad && run && !reset;

endmodule

// File: tb/tb_cdec8_ctrl.sv
// Directed bench for cdec8_ctrl: fetch, operand fetch, ALU/jump/halt paths, illegal decode, run stall, reset.
module tb_cdec8_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [7:0]  I;
    logic [2:0]  SZCy;
    logic [16:0] ctrl;
    logic [7:0]  state;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    cdec8_ctrl dut (
        .clock(clock), .reset(reset), .run(run), .I(I), .SZCy(SZCy),
        .ctrl(ctrl), .state(state), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [16:0] cw(input logic [1:0] m, input logic f, input logic r,
                                       input logic [3:0] d, input logic [4:0] a, input logic [3:0] s);
        return {m, f, r, d, a, s};
    endfunction

    localparam logic [16:0] IDLE = 17'h01E0F;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; I = 8'h24; SZCy = 3'b000;
        ticks(2);
        check("rst_state", 32'(state), 32'h00);
        check("rst_ctrl", 32'(ctrl), 32'(IDLE));
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);

        // LDI B,#
        reset = 1'b0; #1;
        check("f0_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 1, 4'h4, 5'h01, 4'h0)));
        tick(); check("f1_state", 32'(state), 32'h01);
        check("f1_ctrl", 32'(ctrl), 32'(cw(2'b10, 0, 0, 4'h0, 5'h00, 4'h4)));
        tick(); check("f2_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h7, 5'h00, 4'h5)));
        tick(); check("ldi_e0_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 1, 4'h4, 5'h01, 4'h0)));
        tick(); check("ldi_e1_ctrl", 32'(ctrl), 32'(cw(2'b10, 0, 0, 4'h0, 5'h00, 4'h4)));
        tick(); check("ldi_e2_state", 32'(state), 32'h12);
        check("ldi_e2_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h2, 5'h00, 4'h5)));
        tick(); check("ldi_end", 32'(state), 32'h00);

        // ADD A,# (8 cycles)
        I = 8'h53;
        ticks(5); check("addi_e2_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h6, 5'h00, 4'h5)));
        tick(); check("addi_e3_ctrl", 32'(ctrl), 32'(cw(2'b00, 1, 1, 4'hF, 5'h02, 4'h1)));
        tick(); check("addi_e4_state", 32'(state), 32'h14);
        check("addi_e4_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h1, 5'h00, 4'h4)));
        tick(); check("addi_end", 32'(state), 32'h00);

        // SUB A,C (6 cycles)
        I = 8'h56;
        ticks(3); check("sub_e0_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h6, 5'h00, 4'h3)));
        tick(); check("sub_e1_ctrl", 32'(ctrl), 32'(cw(2'b00, 1, 1, 4'hF, 5'h03, 4'h1)));
        tick(); check("sub_e2_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h1, 5'h00, 4'h4)));
        tick(); check("sub_end", 32'(state), 32'h00);

        // JZ taken
        I = 8'h71; SZCy = 3'b010;
        ticks(5); check("jz_t_state", 32'(state), 32'h12);
        check("jz_t_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h0, 5'h00, 4'h5)));
        tick(); check("jz_t_end", 32'(state), 32'h00);

        // JZ not taken
        SZCy = 3'b000;
        ticks(4); check("jz_n_e1", 32'(state), 32'h11);
        tick(); check("jz_n_end", 32'(state), 32'h00);

        // JNCy with carry set: not taken
        I = 8'h74; SZCy = 3'b001;
        ticks(5); check("jnc_n_end", 32'(state), 32'h00);
        SZCy = 3'b000;

        // MOV rr=3 with a run stall in F1
        I = 8'h1C;
        tick(); check("stall_f1", 32'(state), 32'h01);
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_state", 32'(state), 32'h01);
            check("stall_ctrl", 32'(ctrl), 32'(IDLE));
        end
        run = 1'b1; #1;
        check("resume_ctrl", 32'(ctrl), 32'(cw(2'b10, 0, 0, 4'h0, 5'h00, 4'h4)));
        tick(); check("ill_f2_flag", 32'(illegal), 32'h0);
        tick(); check("ill_e0_flag", 32'(illegal), 32'h1);
        check("ill_e0_ctrl", 32'(ctrl), 32'(IDLE));
        tick(); check("ill_after_flag", 32'(illegal), 32'h0);
        check("ill_end", 32'(state), 32'h00);

        // MOV B,C
        I = 8'h16;
        ticks(3); check("mov_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h2, 5'h00, 4'h3)));
        check("mov_legal", 32'(illegal), 32'h0);
        tick(); check("mov_end", 32'(state), 32'h00);

        // ST B,[a]
        I = 8'h44;
        ticks(6); check("st_e3_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h5, 5'h00, 4'h2)));
        tick(); check("st_e4_ctrl", 32'(ctrl), 32'(cw(2'b01, 0, 0, 4'hF, 5'h00, 4'hF)));
        tick(); check("st_end", 32'(state), 32'h00);

        // INC C (5 cycles)
        I = 8'h68;
        ticks(3); check("inc_e0_ctrl", 32'(ctrl), 32'(cw(2'b00, 1, 1, 4'hF, 5'h01, 4'h3)));
        tick(); check("inc_e1_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h3, 5'h00, 4'h4)));
        tick(); check("inc_end", 32'(state), 32'h00);

        // OUT A / IN C
        I = 8'h80;
        ticks(3); check("out_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h8, 5'h00, 4'h1)));
        tick();
        I = 8'h8A;
        ticks(3); check("in_ctrl", 32'(ctrl), 32'(cw(2'b00, 0, 0, 4'h3, 5'h00, 4'h8)));
        tick(); check("in_end", 32'(state), 32'h00);

        // reset in the middle of LD A,[a]
        I = 8'h30;
        ticks(6); check("ld_e3_state", 32'(state), 32'h13);
        check("ld_e3_ctrl", 32'(ctrl), 32'(cw(2'b10, 0, 0, 4'hF, 5'h00, 4'hF)));
        reset = 1'b1; #1;
        check("ld_rst_ctrl", 32'(ctrl), 32'(IDLE));
        tick(); check("ld_rst_state", 32'(state), 32'h00);
        reset = 1'b0;

        // HLT
        I = 8'h01;
        ticks(4); check("hlt_state", 32'(state), 32'hFF);
        check("hlt_flag", 32'(halted), 32'h1);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("hlt_hold", 32'({state, ctrl}), 32'({8'hFF, IDLE}));
        end
        reset = 1'b1;
        tick(); check("hlt_rst_state", 32'(state), 32'h00);
        check("hlt_rst_flag", 32'(halted), 32'h0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
